// File: rtl/spiketpu_pkg.sv
// Shared spiketpu definitions: weight-reader FSM states and the default
// geometry that the weight FIFO and PE array are built around.
package spiketpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } reader_state_e;

  localparam int WEIGHT_WIDTH_DEFAULT = 1;
  localparam int ROWS_DEFAULT         = 8;

endpackage

// File: rtl/weight_fifo_reader_if.sv
// Read-side handshake between a weight FIFO and the column reader.
// The master drives pops; the slave (the FIFO) returns the empty flag and registered data.
interface weight_fifo_reader_if
  import spiketpu_pkg::*;
#(
  parameter int DATA_WIDTH = WEIGHT_WIDTH_DEFAULT
) ();

  logic                  fifo_r_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  modport master (
    output fifo_r_en,
    input  fifo_empty,
    input  fifo_rd_data
  );

  modport slave (
    input  fifo_r_en,
    output fifo_empty,
    output fifo_rd_data
  );

endinterface

// File: rtl/weight_fifo_reader.sv
// Pops ROWS words from the weight FIFO, packs them into one column bus and
// strobes weights_load so every PE row latches its weight on the same cycle.
module weight_fifo_reader
  import spiketpu_pkg::*;
#(
  parameter int ROWS       = ROWS_DEFAULT,
  parameter int DATA_WIDTH = WEIGHT_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  weight_fifo_reader_if.master       fifo,
  output logic [ROWS*DATA_WIDTH-1:0] weights_out,
  output logic                       weights_load,
  output logic                       busy,
  output logic                       done
);

  localparam int CNT_W = $clog2(ROWS + 1);
  localparam int W     = ROWS * DATA_WIDTH;

  localparam logic [CNT_W-1:0] ROWS_CNT = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0] LAST_CAP = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  reader_state_e    state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
  logic             rd_pending_q, rd_pending_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [W-1:0]     weights_q, weights_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             r_en;
  logic [W-1:0]     shifted;

  // New words enter at the top slice, so the first word popped ends up in slice 0.
  assign shifted = {fifo.fifo_rd_data, shift_q[W-1:DATA_WIDTH]};

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    cap_cnt_d    = cap_cnt_q;
    rd_pending_d = 1'b0;
    shift_d      = shift_q;
    weights_d    = weights_q;
    load_d       = 1'b0;
    busy_d       = busy_q;
    r_en         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
          busy_d      = 1'b1;
          state_d     = FETCH;
        end
      end

      FETCH: begin
        r_en         = (issue_cnt_q < ROWS_CNT) && !fifo.fifo_empty;
        rd_pending_d = r_en;
        if (r_en) begin
          issue_cnt_d = issue_cnt_q + CNT_ONE;
        end
        // Read data arrives one cycle after the pop, tracked by rd_pending_q.
        if (rd_pending_q) begin
          shift_d   = shifted;
          cap_cnt_d = cap_cnt_q + CNT_ONE;
          if (cap_cnt_q == LAST_CAP) begin
            weights_d = shifted;
            load_d    = 1'b1;
            state_d   = LOAD;
          end
        end
      end

      LOAD: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      issue_cnt_q  <= '0;
      cap_cnt_q    <= '0;
      rd_pending_q <= 1'b0;
      shift_q      <= '0;
      weights_q    <= '0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      cap_cnt_q    <= cap_cnt_d;
      rd_pending_q <= rd_pending_d;
      shift_q      <= shift_d;
      weights_q    <= weights_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
    end
  end

  assign fifo.fifo_r_en = r_en;
  assign weights_out    = weights_q;
  assign weights_load   = load_q;
  assign done           = load_q;
  assign busy           = busy_q;

endmodule

// File: doc/weight_fifo_reader.md
Name: weight_fifo_reader

Overview:
Drains the per-column weight FIFO and delivers one full column of weights to the systolic PE array for weight-stationary operation. On a start request it pops exactly ROWS words from the FIFO. It honours the FIFO's empty flag and its one-cycle registered read latency. It assembles the words into a parallel column bus, then pulses a load strobe so every PE row latches its weight on the same cycle.

Parameters:
ROWS, 8, number of PE rows fed; words popped per load; must be >= 2
DATA_WIDTH, 1, width of one weight word; must match the FIFO data width
CNT_W, $clog2(ROWS+1), localparam; width of the issue and capture counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request one column load; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_rd_data  input  DATA_WIDTH  FIFO registered read data, valid the cycle after fifo_r_en
fifo_r_en  output  1  FIFO pop request
weights_out  output  ROWS*DATA_WIDTH  column weights; slice k ([k*DATA_WIDTH +: DATA_WIDTH]) drives PE row k
weights_load  output  1  one-cycle strobe; PEs latch weights_out
busy  output  1  high in FETCH and LOAD
done  output  1  one-cycle pulse, coincident with weights_load

Behaviour:
- Reset: state=IDLE; issue_cnt=0; cap_cnt=0; rd_pending=0; shift_reg=0; weights_out=0; fifo_r_en=0; weights_load=0; busy=0; done=0.
- States: IDLE, FETCH, LOAD.
- IDLE:
  - start=1 clears both counters and moves to FETCH on the next edge.
  - start=0 stays in IDLE.
- FETCH:
  - fifo_r_en = (issue_cnt < ROWS) && !fifo_empty. This is combinational from registered state plus fifo_empty.
  - fifo_r_en is never asserted while fifo_empty=1, so the block cannot cause FIFO underflow.
  - Each cycle with fifo_r_en=1: issue_cnt++ and rd_pending<=1. Otherwise rd_pending<=0.
  - Each cycle with rd_pending=1: capture fifo_rd_data and increment cap_cnt.
  - Capture shifts into the MSB slice and shifts shift_reg right by DATA_WIDTH. After ROWS captures, the k-th popped word (k from 0) sits in slice k.
  - On the edge of the ROWS-th capture, weights_out <= the fully shifted value, including the word captured on that edge, and state moves to LOAD.
- LOAD:
  - Lasts exactly one cycle; weights_load=1 and done=1.
  - Returns to IDLE on the next edge.
  - start in this cycle is ignored.
- weights_out holds its value until the next LOAD or reset.
- Latency: start sampled in cycle 0 with no empty stalls gives fifo_r_en in cycles 1..ROWS and weights_load in cycle ROWS+2.
- Empty stalls: each cycle the FIFO is empty while words remain to issue delays weights_load by one cycle. No words are lost or duplicated.
- start while busy=1 is ignored; there is no queueing.
- Reset mid-operation:
  - Returns to IDLE immediately.
  - Any in-flight read data is discarded.
  - The FIFO is reset in the same cycle, by system contract.
- Counters never wrap: issue_cnt saturates at ROWS and cap_cnt ends at ROWS.

Decomposition:
- Shared package spiketpu_pkg holds:
  - the state enum (IDLE, FETCH, LOAD);
  - the default weight width constant shared with the FIFO;
  - the default ROWS.
- No sub-module is needed. The shift register and counters are inline; one FSM plus datapath stays within about 150 lines.

Test Plan:
1. Assert rst for 2 cycles mid-idle -> all outputs 0, weights_out=0, fifo_r_en=0.
2. ROWS=4, DATA_WIDTH=8, FIFO preloaded 0x11,0x22,0x33,0x44; start pulse in cycle 0 -> fifo_r_en high cycles 1-4; weights_load=done=1 only in cycle 6; weights_out=0x44332211; busy high cycles 1-6.
3. Same preload; FIFO empty during cycles 2-4 (words trickled in) -> fifo_r_en never high while empty; weights_load in cycle 9; weights_out=0x44332211.
4. start re-pulsed in cycles 3 and 6 of an ongoing load -> ignored; exactly 4 pops; single weights_load pulse.
5. rst asserted in cycle 3 after 2 pops, FIFO also reset and refilled with 0xA1..0xA4; start again -> weights_out=0xA4A3A2A1; no stale words.
6. Back-to-back: 8 words preloaded, start in cycle 0 and cycle 7 -> loads in cycles 6 and 13, with weights_out=0x44332211 then 0x88776655.
